// File: rtl/spr_dump.sv
// Walks the SPRs selected by a mask in ascending order, reading each through the shared
// spr_ram read port and emitting one {index, data} beat per register on a valid/ready stream.
module spr_dump #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] sel_mask,
  output logic [4:0]  Sa,
  input  logic [31:0] Sout,
  output logic        Slock,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [4:0]  m_idx,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRead, StHold, StFin} state_e;

  // Sa is held for RD_LAT+1 cycles; capture happens on the final one.
  localparam logic [1:0] WaitLast = 2'(RD_LAT);

  state_e      state;
  logic [31:0] rem;
  logic [1:0]  wait_cnt;
  logic [31:0] cur_bit;
  logic        rem_single;

  // Index 0 has the highest priority.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign cur_bit    = 32'd1 << Sa;
  // Only evaluated while rem still holds the bit being captured, so rem is non-zero here.
  assign rem_single = ((rem & (rem - 32'd1)) == 32'd0);

  assign busy  = (state != StIdle);
  assign Slock = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      rem      <= '0;
      wait_cnt <= '0;
      Sa       <= '0;
      m_valid  <= 1'b0;
      m_idx    <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            if (sel_mask != 32'd0) begin
              rem      <= sel_mask;
              Sa       <= lowest_set(sel_mask);
              wait_cnt <= '0;
              state    <= StRead;
            end else begin
              state <= StFin;
            end
          end
        end
        StRead: begin
          if (wait_cnt == WaitLast) begin
            m_data  <= Sout;
            m_idx   <= Sa;
            m_last  <= rem_single;
            m_valid <= 1'b1;
            rem     <= rem & ~cur_bit;
            state   <= StHold;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        StHold: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (rem == 32'd0) begin
              state <= StFin;
            end else begin
              // Present the next address on the handshake edge to save a cycle.
              Sa       <= lowest_set(rem);
              wait_cnt <= '0;
              state    <= StRead;
            end
          end
        end
        StFin: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spr_dump.sv
// Randomized self-checking bench for spr_dump, with a behavioural spr_ram read model and a
// beat-list reference derived directly from the mask and memory contents.
module tb_spr_dump;

  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] sel_mask = '0;
  logic        m_ready = 1'b0;
  logic [4:0]  Sa;
  logic [31:0] Sout;
  logic        Slock;
  logic        m_valid;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  logic [31:0] sout_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sout_q <= mem[Sa];
  assign Sout = (RD_LAT == 0) ? mem[Sa] : sout_q;

  spr_dump #(.RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel_mask (sel_mask),
    .Sa       (Sa),
    .Sout     (Sout),
    .Slock    (Slock),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_idx    (m_idx),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete dump: start at the edge after the current negedge (edge 0), then observe each
  // cycle at the negedge. Cycle c is the interval ending at edge c.
  task automatic run_dump(input logic [31:0] mask, input int ready_pct, input int stall,
                          input bit poke);
    logic [37:0] exp_q[$];
    logic [4:0]  first_idx;
    int          hi;
    int          exp_rise;
    int          last_hs;
    int          dones;
    int          busy_cycles;
    int          age;
    bit          prev_valid;
    bit          finished;
    bit          hs;

    hi          = -1;
    first_idx   = '0;
    exp_rise    = 2 + RD_LAT;
    last_hs     = 0;
    dones       = 0;
    busy_cycles = 0;
    age         = 0;
    prev_valid  = 1'b0;
    finished    = 1'b0;

    for (int i = 0; i < 32; i++) if (mask[i]) hi = i;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        if (exp_q.size() == 0) first_idx = 5'(i);
        exp_q.push_back({(i == hi), 5'(i), mem[i]});
      end
    end

    @(negedge clk);
    check_eq("slock_before_start", 64'(Slock), 64'(0));
    start    = 1'b1;
    sel_mask = mask;

    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      sel_mask = $urandom();
      if (poke && cyc == 5 && busy) begin
        start    = 1'b1;
        sel_mask = ~mask;
      end
      if (busy) busy_cycles++;
      if (cyc == 1 && mask != 32'd0) check_eq("sa_first", 64'(Sa), 64'(first_idx));

      if (m_valid) begin
        if (!prev_valid) begin
          check_eq("valid_rise_cycle", 64'(cyc), 64'(exp_rise));
          age = 0;
        end
        if (exp_q.size() == 0) check_eq("extra_beat", 64'(1), 64'(0));
        else check_eq("beat", 64'({m_last, m_idx, m_data}), 64'(exp_q[0]));
      end

      m_ready = (age >= stall) && ($urandom_range(99) < ready_pct);
      hs      = m_valid && m_ready;
      if (hs) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last_hs  = cyc;
        exp_rise = cyc + 2 + RD_LAT;
      end
      if (m_valid) age++;
      prev_valid = m_valid && !hs;

      if (done) begin
        dones++;
        check_eq("done_cycle", 64'(cyc), 64'(last_hs + 2));
        check_eq("busy_slock_at_done", 64'({busy, Slock}), 64'(0));
        finished = 1'b1;
      end
    end

    start   = 1'b0;
    m_ready = 1'b0;
    check_eq("beats_left", 64'(exp_q.size()), 64'(0));
    check_eq("done_count", 64'(dones), 64'(1));
    if (mask == 32'd0) check_eq("busy_cycles_empty", 64'(busy_cycles), 64'(1));
  endtask

  task automatic reset_in_hold();
    @(negedge clk);
    start    = 1'b1;
    sel_mask = 32'h0000_ffff;
    m_ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
    check_eq("hold_reached", 64'(m_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_eq("reset_abort", 64'({m_valid, busy, Slock}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("no_done_after_reset", 64'({done, busy}), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;

    #1;
    check_eq("reset_outputs",
             64'({Sa, Slock, m_valid, m_idx, m_data, m_last, busy, done}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    mem[5]  = 32'hA5A5_A5A5;
    mem[10] = 32'hDEAD_BEEF;
    run_dump(32'h0000_0420, 100, 0, 1'b0);
    run_dump(32'h0000_0000, 100, 0, 1'b0);
    run_dump(32'h0000_0020, 100, 6, 1'b0);

    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h0101_0101;
    run_dump(32'hFFFF_FFFF, 100, 0, 1'b0);
    run_dump(32'hFFFF_FFFF, 100, 0, 1'b1);

    reset_in_hold();
    run_dump(32'h8000_0000, 100, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      if (!Slock) begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom();
      end
      run_dump($urandom() & $urandom(), 30 + int'($urandom_range(70)),
               int'($urandom_range(2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
